// File: rtl/mac_dot_pkg.sv
// Shared widths, extension and saturation helpers for the mac_dot_accumulate slice.
// Build option MAC_DOT_SAT_EN selects saturating (defined) or wrapping (undefined) adds.
package mac_dot_pkg;

`ifdef MAC_DOT_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r++;
        return r;
    endfunction

    function automatic int unsigned prod_w(input int unsigned dw);
        return 2 * dw;
    endfunction

    function automatic int unsigned tree_w(input int unsigned dw, input int unsigned lanes);
        return prod_w(dw) + clog2(lanes);
    endfunction

    // Sign- or zero-extends the low w bits of v to 64 bits.
    function automatic logic [63:0] extend(input logic [63:0] v, input int unsigned w, input bit sgn);
        logic [63:0] r;
        r = v;
        for (int unsigned i = w; i < 64; i++) r[i] = sgn ? v[w-1] : 1'b0;
        return r;
    endfunction

    function automatic logic [63:0] sat_hi(input int unsigned w, input bit sgn);
        logic [63:0] r;
        r = '0;
        for (int unsigned i = 0; i < w - (sgn ? 1 : 0); i++) r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [63:0] sat_lo(input int unsigned w, input bit sgn);
        logic [63:0] r;
        r = '0;
        if (sgn) r[w-1] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/mac_dot_tree.sv
// S1 lane product registers followed by the registered S2 adder tree.
// Sideband tag bits travel alongside each beat; all stages stall on en.
module mac_dot_tree
    import mac_dot_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int LANES  = 4,
    parameter int SIGNED = 0,
    parameter int TAG_W  = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               en,
    input  logic                               in_valid,
    input  logic [TAG_W-1:0]                   in_tag,
    input  logic [LANES*DATA_W-1:0]            in_a,
    input  logic [LANES*DATA_W-1:0]            in_b,
    output logic                               out_valid,
    output logic [TAG_W-1:0]                   out_tag,
    output logic [tree_w(DATA_W, LANES)-1:0]   out_sum
);
    localparam int unsigned PW  = prod_w(DATA_W);
    localparam int unsigned TW  = tree_w(DATA_W, LANES);
    localparam bit          SGN = (SIGNED != 0);

    logic [PW-1:0]    prod [LANES];
    logic             s1_valid;
    logic [TAG_W-1:0] s1_tag;
    logic [TW-1:0]    tree_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
        end else if (en) begin
            s1_valid  <= in_valid;
            out_valid <= s1_valid;
        end
    end

    // Operands are extended to the product width first, so the low bits of the
    // product are correct for both signed and unsigned operation.
    always_ff @(posedge clk) begin
        if (en) begin
            s1_tag <= in_tag;
            for (int unsigned i = 0; i < LANES; i++) begin
                prod[i] <= PW'(extend(64'(in_a[i*DATA_W +: DATA_W]), DATA_W, SGN))
                         * PW'(extend(64'(in_b[i*DATA_W +: DATA_W]), DATA_W, SGN));
            end
            out_tag <= s1_tag;
            out_sum <= tree_sum;
        end
    end

    always_comb begin
        tree_sum = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            tree_sum += TW'(extend(64'(prod[i]), PW, SGN));
        end
    end

endmodule

// File: rtl/mac_dot_accumulate.sv
// Pipelined multi-lane dot-product accumulator: one biased result per in_last packet.
// Build option MAC_DOT_SAT_EN makes the accumulate and bias adds saturate instead of wrap.
module mac_dot_accumulate
    import mac_dot_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int LANES  = 4,
    parameter int ACC_W  = 24,
    parameter int SIGNED = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_last,
    input  logic [LANES*DATA_W-1:0] in_a,
    input  logic [LANES*DATA_W-1:0] in_b,
    input  logic [DATA_W-1:0]       in_bias,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACC_W-1:0]        out_data,
    output logic                    out_ovf
);
    localparam int unsigned     TW     = tree_w(DATA_W, LANES);
    localparam int unsigned     TAG_W  = DATA_W + 1;
    localparam bit              SGN    = (SIGNED != 0);
    localparam logic [ACC_W-1:0] SAT_HI = ACC_W'(sat_hi(ACC_W, SGN));
    localparam logic [ACC_W-1:0] SAT_LO = ACC_W'(sat_lo(ACC_W, SGN));

    logic                    en, accept, first;
    logic [DATA_W-1:0]       pkt_bias, beat_bias;
    logic                    s0_valid, s0_last;
    logic [DATA_W-1:0]       s0_bias;
    logic [LANES*DATA_W-1:0] s0_a, s0_b;
    logic                    s2_valid;
    logic [TAG_W-1:0]        s2_tag;
    logic [TW-1:0]           s2_sum;
    logic [ACC_W-1:0]        acc, s2_ext, bias_ext, sum, res;
    logic                    pkt_ovf, flag1, flag2;
    logic [ACC_W:0]          add1, add2;

    // Returns {overflow, result}; the result is clamped when saturation is built in.
    function automatic logic [ACC_W:0] add_chk(input logic [ACC_W-1:0] x, input logic [ACC_W-1:0] y);
        logic [ACC_W:0]   full;
        logic [ACC_W-1:0] r;
        logic             ovf;
        full = {1'b0, x} + {1'b0, y};
        r    = full[ACC_W-1:0];
        ovf  = SGN ? ((x[ACC_W-1] == y[ACC_W-1]) && (r[ACC_W-1] != x[ACC_W-1])) : full[ACC_W];
        if (SAT_EN && ovf) r = (SGN && x[ACC_W-1]) ? SAT_LO : SAT_HI;
        return {ovf, r};
    endfunction

    assign en        = !(out_valid && !out_ready);
    assign in_ready  = en && !rst;
    assign accept    = in_valid && in_ready;
    assign beat_bias = first ? in_bias : pkt_bias;

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid <= 1'b0;
            first    <= 1'b1;
            pkt_bias <= '0;
        end else begin
            if (en) s0_valid <= accept;
            if (accept) begin
                first <= in_last;
                if (first) pkt_bias <= in_bias;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            s0_a    <= in_a;
            s0_b    <= in_b;
            s0_last <= in_last;
            s0_bias <= beat_bias;
        end
    end

    mac_dot_tree #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .SIGNED (SIGNED),
        .TAG_W  (TAG_W)
    ) u_tree (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (s0_valid),
        .in_tag    ({s0_last, s0_bias}),
        .in_a      (s0_a),
        .in_b      (s0_b),
        .out_valid (s2_valid),
        .out_tag   (s2_tag),
        .out_sum   (s2_sum)
    );

    // A saturated packet keeps its clamped value: later adds are skipped.
    always_comb begin
        s2_ext   = ACC_W'(extend(64'(s2_sum), TW, SGN));
        bias_ext = ACC_W'(extend(64'(s2_tag[DATA_W-1:0]), DATA_W, SGN));
        add1     = add_chk(acc, s2_ext);
        sum      = add1[ACC_W-1:0];
        flag1    = pkt_ovf | add1[ACC_W];
        if (SAT_EN && pkt_ovf) sum = acc;
        add2     = add_chk(sum, bias_ext);
        res      = add2[ACC_W-1:0];
        flag2    = flag1 | add2[ACC_W];
        if (SAT_EN && flag1) res = sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            pkt_ovf   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            if (en && s2_valid) begin
                if (s2_tag[TAG_W-1]) begin
                    out_valid <= 1'b1;
                    out_data  <= res;
                    out_ovf   <= flag2;
                    acc       <= '0;
                    pkt_ovf   <= 1'b0;
                end else begin
                    acc     <= sum;
                    pkt_ovf <= flag1;
                end
            end
        end
    end

endmodule
